reconstruct_top: RTL and testbench
==================================

RECONSTRUCT_TOP -- requirements
Module: reconstruct_top

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port: start  input  1  request to begin a reconstruction; sampled only in IDLE.
REQ-005 Port: mode  input  1  0 = full reconstruction (R+B+C+D); 1 = short reconstruction (R+D); sampled with start.
REQ-006 Port: R  input  WIDTH  difference value produced by the forward subtract datapath.
REQ-007 Port: B  input  WIDTH  first subtrahend to add back.
REQ-008 Port: C  input  WIDTH  second subtrahend to add back.
REQ-009 Port: D  input  WIDTH  third subtrahend to add back.
REQ-010 Port: A_out  output  WIDTH  reconstructed minuend (accumulator register).
REQ-011 Port: carry  output  1  sticky carry-out of any addition in the current operation.
REQ-012 Port: busy  output  1  high in every state except IDLE.
REQ-013 Port: done  output  1  one-cycle pulse when A_out holds the final result.

Function
REQ-014 The FSM SHALL use states IDLE, LOAD, ADD_B, ADD_C, ADD_D, DONE.
REQ-015 IDLE SHALL go to LOAD when start=1, else remain IDLE.
REQ-016 On the IDLE->LOAD edge, mode, B, C and D SHALL be captured into internal registers; later input changes SHALL NOT affect the operation.
REQ-017 LOAD SHALL write R (sampled in LOAD) into the accumulator, clear carry, then go to ADD_B when mode=0 or ADD_D when mode=1.
REQ-018 ADD_B->ADD_C->ADD_D SHALL each add the captured operand to the accumulator, in that order.
REQ-019 ADD_D SHALL go to DONE; DONE SHALL go unconditionally to IDLE.
REQ-020 Additions SHALL be unsigned modulo 2^WIDTH; any carry-out SHALL set carry, which stays set until the next LOAD.
REQ-021 done SHALL be 1 exactly in DONE; busy SHALL be 1 in LOAD through DONE.
REQ-022 Latency: done SHALL assert 5 cycles after the start-sampling edge for mode=0 and 3 cycles for mode=1.
REQ-023 A_out and carry SHALL hold their final values after DONE until the next LOAD.
REQ-024 start asserted in any state other than IDLE, including DONE, SHALL be ignored.
REQ-025 start held high continuously SHALL launch a new operation on each return to IDLE (one idle cycle between operations).

Reset
REQ-026 reset=0 SHALL immediately force the state to IDLE, A_out=0, carry=0, busy=0, done=0, and clear the captured operand registers.
REQ-027 Reset asserted mid-operation SHALL abort it without producing a done pulse; operation resumes only on a new start after reset deasserts.

Structure
REQ-028 State encodings and the default WIDTH SHALL reside in a shared package used by this block and the forward datapath.
REQ-029 The adder SHALL be a separate sub-module adder_unit (WIDTH-bit sum plus carry-out), mirroring the forward subtractor.
REQ-030 Operand selection (B/C/D) SHALL be a 3-to-1 mux driven by the FSM state.

Verification
REQ-031 mode=0, R=10, B=1, C=2, D=3, start pulse -> done 5 cycles later, A_out=16, carry=0.
REQ-032 mode=0, R=0xF0, B=0x10, C=0x00, D=0x01 -> A_out=0x01, carry=1 at done.
REQ-033 mode=1, R=0x20, D=0x05 (B, C arbitrary) -> done 3 cycles after start, A_out=0x25, carry=0.
REQ-034 start pulsed again during ADD_C, with B/C/D changed after capture -> ignored, result unchanged from captured operands, exactly one done pulse.
REQ-035 reset=0 asserted during ADD_C -> A_out=0, carry=0, busy=0 immediately; no done; new start after release completes normally.

Source files
------------

// File: rtl/reconstruct_pkg.sv
// ----------------------------------------------------------------------------
// reconstruct_pkg
// Shared definitions for the subtract/reconstruct datapath pair.
//   RECON_WIDTH : default operand/result width
//   state_t     : reconstruction FSM state encoding (also exported on the
//                 top-level debug port)
// ----------------------------------------------------------------------------
package reconstruct_pkg;

    localparam int RECON_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ADD_B = 3'd2,
        ADD_C = 3'd3,
        ADD_D = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/reconstruct_adder_unit.sv
// ----------------------------------------------------------------------------
// adder_unit
// Unsigned WIDTH-bit adder, the counterpart of the forward subtractor.
//   a, b      : operands
//   sum       : (a + b) mod 2^WIDTH
//   carry_out : carry out of the top bit
// ----------------------------------------------------------------------------
module adder_unit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    // Zero-extend both operands so the extra bit catches the carry.
    assign {carry_out, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/reconstruct_top.sv
// ----------------------------------------------------------------------------
// reconstruct_top
// Rebuilds the minuend A from the difference R and the subtrahends B, C, D
// by accumulating A = R (+ B + C) + D over several cycles.
//
// Ports
//   clk        : clock, rising-edge active
//   reset      : asynchronous reset, active low
//   start      : begin an operation (sampled only in IDLE)
//   mode       : 0 = R+B+C+D, 1 = R+D (captured with start)
//   R          : difference value, sampled in LOAD
//   B, C, D    : subtrahends, captured on the start-accepting edge
//   A_out      : accumulator / reconstructed minuend
//   carry      : sticky carry-out of the current operation
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse while A_out holds the final result
//   state_dbg  : current FSM state
//
// Handshake: start is a request level observed only while busy=0 (IDLE); the
// edge that sees start=1 in IDLE accepts it and raises busy on the next
// cycle. done is a single-cycle completion pulse with no back-pressure;
// A_out/carry stay valid from done until the next LOAD.
// ----------------------------------------------------------------------------
module reconstruct_top
    import reconstruct_pkg::*;
#(
    parameter int WIDTH = RECON_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] R,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] A_out,
    output logic             carry,
    output logic             busy,
    output logic             done,
    output state_t           state_dbg
);

    state_t           state;
    logic             mode_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] sum;
    logic             sum_carry;

    assign state_dbg = state;

    // Operand selection follows the add state; D doubles as the default so
    // the mux is a plain 3-to-1.
    always_comb begin
        operand = d_q;
        case (state)
            ADD_B:   operand = b_q;
            ADD_C:   operand = c_q;
            default: operand = d_q;
        endcase
    end

    adder_unit #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a         (A_out),
        .b         (operand),
        .sum       (sum),
        .carry_out (sum_carry)
    );

    // busy and done are registered alongside the state so they always match
    // the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            A_out  <= '0;
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            mode_q <= 1'b0;
            b_q    <= '0;
            c_q    <= '0;
            d_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= LOAD;
                        busy   <= 1'b1;
                        mode_q <= mode;
                        b_q    <= B;
                        c_q    <= C;
                        d_q    <= D;
                    end
                end
                LOAD: begin
                    A_out <= R;
                    carry <= 1'b0;
                    state <= mode_q ? ADD_D : ADD_B;
                end
                ADD_B: begin
                    A_out <= sum;
                    carry <= carry | sum_carry;
                    state <= ADD_C;
                end
                ADD_C: begin
                    A_out <= sum;
                    carry <= carry | sum_carry;
                    state <= ADD_D;
                end
                ADD_D: begin
                    A_out <= sum;
                    carry <= carry | sum_carry;
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reconstruct_top.sv
// ----------------------------------------------------------------------------
// tb_reconstruct_top
// Directed and random checks of reconstruct_top with an expected-result queue.
// ----------------------------------------------------------------------------
module tb_reconstruct_top;
    import reconstruct_pkg::*;

    localparam int W = RECON_WIDTH;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         mode;
    logic [W-1:0] r;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] d;
    logic [W-1:0] a_out;
    logic         carry;
    logic         busy;
    logic         done;
    state_t       state_dbg;

    always #5 clk = ~clk;

    reconstruct_top #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .R         (r),
        .B         (b),
        .C         (c),
        .D         (d),
        .A_out     (a_out),
        .carry     (carry),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [W:0] exp_q[$];   // {carry, A}
    int n_checks = 0;
    int n_fails  = 0;
    int cyc;

    function automatic logic [W:0] model(input logic m, input logic [W-1:0] rv,
                                         input logic [W-1:0] bv, input logic [W-1:0] cv,
                                         input logic [W-1:0] dv);
        logic [W-1:0] acc;
        logic [W:0]   t;
        logic         cy;
        acc = rv;
        cy  = 1'b0;
        if (!m) begin
            t = {1'b0, acc} + {1'b0, bv}; cy = cy | t[W]; acc = t[W-1:0];
            t = {1'b0, acc} + {1'b0, cv}; cy = cy | t[W]; acc = t[W-1:0];
        end
        t = {1'b0, acc} + {1'b0, dv}; cy = cy | t[W]; acc = t[W-1:0];
        return {cy, acc};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drive a start request from IDLE; returns at the negedge inside LOAD with cyc=1.
    task automatic launch(input logic m, input logic [W-1:0] rv, input logic [W-1:0] bv,
                          input logic [W-1:0] cv, input logic [W-1:0] dv);
        @(negedge clk);
        mode  = m;
        r     = rv;
        b     = bv;
        c     = cv;
        d     = dv;
        start = 1'b1;
        exp_q.push_back(model(m, rv, bv, cv, dv));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check("busy_in_load", busy, 1'b1);
    endtask

    // Wait (bounded) for done, check latency and result, then the cycle after.
    task automatic finish_op(input int lat, input string tag);
        logic [W:0] e;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, lat);
        e = exp_q.pop_front();
        check({tag, "_a"}, a_out, e[W-1:0]);
        check({tag, "_carry"}, carry, e[W]);
        check({tag, "_busy_done"}, busy, 1'b1);
        check({tag, "_state_done"}, state_dbg, DONE);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_busy_off"}, busy, 1'b0);
        check({tag, "_a_hold"}, a_out, e[W-1:0]);
        check({tag, "_carry_hold"}, carry, e[W]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int           pulses;
        logic         m;
        logic [W-1:0] rv, bv, cv, dv;
        logic [W:0]   e;

        reset = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        r = '0; b = '0; c = '0; d = '0;
        repeat (2) @(negedge clk);
        check("rst_a", a_out, '0);
        check("rst_carry", carry, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_state", state_dbg, IDLE);
        reset = 1'b1;
        @(negedge clk);

        // Basic full and short reconstructions
        launch(1'b0, 8'd10, 8'd1, 8'd2, 8'd3);
        finish_op(5, "full_basic");
        launch(1'b0, 8'hF0, 8'h10, 8'h00, 8'h01);
        finish_op(5, "full_carry");
        launch(1'b1, 8'h20, 8'hAA, 8'hBB, 8'h05);
        finish_op(3, "short_basic");

        // Operands changed after capture and start re-pulsed in ADD_C
        launch(1'b0, 8'h30, 8'h04, 8'h05, 8'h06);
        b = 8'hFF; c = 8'hFF; d = 8'hFF; mode = 1'b1;
        @(negedge clk); cyc++;
        r = 8'hEE;
        @(negedge clk); cyc++;
        check("ignore_state_add_c", state_dbg, ADD_C);
        start = 1'b1;
        @(negedge clk); cyc++;
        start = 1'b0;
        finish_op(5, "ignore_mid");
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("ignore_extra_done", pulses, 0);

        // start held across ADD_D and DONE: the DONE-cycle sample is ignored
        launch(1'b1, 8'h7F, 8'h00, 8'h00, 8'h81);
        @(negedge clk); cyc++;
        start = 1'b1;
        finish_op(3, "start_in_done");
        start = 1'b0;
        @(negedge clk);
        check("start_in_done_idle", state_dbg, IDLE);

        // start held high: back-to-back operations with one idle cycle between
        @(negedge clk);
        mode = 1'b0; r = 8'h01; b = 8'h02; c = 8'h03; d = 8'h04;
        start = 1'b1;
        exp_q.push_back(model(1'b0, 8'h01, 8'h02, 8'h03, 8'h04));
        exp_q.push_back(model(1'b0, 8'h01, 8'h02, 8'h03, 8'h04));
        cyc = 0;
        @(posedge clk);
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("held_first_latency", cyc, 5);
        e = exp_q.pop_front();
        check("held_first_a", a_out, e[W-1:0]);
        cyc = 0;
        @(negedge clk); cyc++;
        check("held_gap_busy", busy, 1'b0);
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("held_interval", cyc, 6);
        e = exp_q.pop_front();
        check("held_second_a", a_out, e[W-1:0]);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("held_drain_busy", busy, 1'b0);

        // Asynchronous reset in ADD_C aborts without done
        launch(1'b0, 8'h11, 8'h22, 8'h33, 8'h44);
        @(negedge clk);
        @(negedge clk);
        check("abort_state_add_c", state_dbg, ADD_C);
        #2 reset = 1'b0;
        #1;
        check("abort_a", a_out, '0);
        check("abort_carry", carry, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_state", state_dbg, IDLE);
        void'(exp_q.pop_back());
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) pulses++;
        end
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        check("abort_stays_idle", busy, 1'b0);
        launch(1'b0, 8'h11, 8'h22, 8'h33, 8'h44);
        finish_op(5, "after_abort");

        // Random operations in both modes
        for (int i = 0; i < 8; i++) begin
            m  = 1'($urandom_range(0, 1));
            rv = W'($urandom_range(0, 255));
            bv = W'($urandom_range(0, 255));
            cv = W'($urandom_range(0, 255));
            dv = W'($urandom_range(0, 255));
            launch(m, rv, bv, cv, dv);
            finish_op(m ? 3 : 5, "rand");
        end

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
